// File: rtl/ign_coil_sim.sv
// ign_coil_sim: synthetic ignition-coil waveform generator driven by the 1 MHz pulse1m tick.
// Emits a coil signal with programmable period and dwell, either continuously or as a
// fixed-count burst. Start latency is the sysclk edge that samples the starting pulse1m.
// An abort (run low) takes effect on the next sysclk.
//
// Ports:
//   sysclk, sysreset       - 50 MHz clock; asynchronous active-high reset
//   pulse1m                - one-sysclk strobe at 1 MHz; all waveform timing counts these
//   run                    - level enable for waveform generation
//   period_us              - coil cycle length in us (rising edge to rising edge)
//   dwell_us               - coil-high time per cycle in us (clamped to period_us-1)
//   burst_len              - number of cycles to emit (0 = continuous)
//   ign_coil               - registered coil waveform
//   spark_event            - one-sysclk pulse, one sysclk after each natural coil falling edge
//   busy                   - high while generating
//   burst_done             - one-sysclk pulse when a finite burst completes
//   cycle_count            - cycles completed since the last start
module ign_coil_sim #(
  parameter int CW = 16
) (
  input  logic          sysclk,
  input  logic          sysreset,
  input  logic          pulse1m,
  input  logic          run,
  input  logic [CW-1:0] period_us,
  input  logic [CW-1:0] dwell_us,
  input  logic [CW-1:0] burst_len,
  output logic          ign_coil,
  output logic          spark_event,
  output logic          busy,
  output logic          burst_done,
  output logic [CW-1:0] cycle_count
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] phase, phase_nxt;
  logic [CW-1:0] per_l, per_nxt;
  logic [CW-1:0] dw_l, dw_nxt;
  logic [CW-1:0] bl_l, bl_nxt;
  logic [CW-1:0] count_nxt;
  logic          coil_nxt;
  logic          done_nxt;
  logic          fall_pend, fall_nxt;

  logic [CW-1:0] dw_e;       // clamped dwell of the cycle in progress
  logic [CW-1:0] dw_new;     // clamped dwell of values about to be latched
  logic [CW-1:0] count_inc;
  logic [CW-1:0] phase_inc;
  logic          cyc_end;

  // Clamp dwell so every cycle has at least one low microsecond.
  function automatic logic [CW-1:0] clamp_dwell(input logic [CW-1:0] per,
                                                input logic [CW-1:0] dw);
    return (dw < per) ? dw : (per - CW'(1));
  endfunction

  assign dw_e      = clamp_dwell(per_l, dw_l);
  assign dw_new    = clamp_dwell(period_us, dwell_us);
  assign count_inc = cycle_count + CW'(1);
  assign phase_inc = phase + CW'(1);
  assign cyc_end   = (phase == (per_l - CW'(1)));
  assign busy      = (state == RUN);

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state       <= IDLE;
      phase       <= '0;
      per_l       <= '0;
      dw_l        <= '0;
      bl_l        <= '0;
      cycle_count <= '0;
      ign_coil    <= 1'b0;
      burst_done  <= 1'b0;
      fall_pend   <= 1'b0;
      spark_event <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      per_l       <= per_nxt;
      dw_l        <= dw_nxt;
      bl_l        <= bl_nxt;
      cycle_count <= count_nxt;
      ign_coil    <= coil_nxt;
      burst_done  <= done_nxt;
      // The spark trails the falling edge by one sysclk.
      fall_pend   <= fall_nxt;
      spark_event <= fall_pend;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    per_nxt   = per_l;
    dw_nxt    = dw_l;
    bl_nxt    = bl_l;
    count_nxt = cycle_count;
    coil_nxt  = ign_coil;
    done_nxt  = 1'b0;
    fall_nxt  = 1'b0;

    case (state)
      IDLE: begin
        coil_nxt  = 1'b0;
        phase_nxt = '0;
        if (pulse1m && run && (period_us != '0)) begin
          per_nxt   = period_us;
          dw_nxt    = dwell_us;
          bl_nxt    = burst_len;
          count_nxt = '0;
          state_nxt = RUN;
          coil_nxt  = (dw_new != '0);
        end
      end

      RUN: begin
        if (!run) begin
          // Abort is immediate; a coincident cycle end is still counted.
          state_nxt = IDLE;
          phase_nxt = '0;
          coil_nxt  = 1'b0;
          if (pulse1m && cyc_end) count_nxt = count_inc;
        end else if (pulse1m) begin
          if (cyc_end) begin
            phase_nxt = '0;
            count_nxt = count_inc;
            // New period/dwell only take effect at cycle boundaries.
            per_nxt   = period_us;
            dw_nxt    = dwell_us;
            coil_nxt  = (dw_new != '0);
            if ((bl_l != '0) && (count_inc == bl_l)) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
              coil_nxt  = 1'b0;
            end else if (period_us == '0) begin
              state_nxt = IDLE;
              coil_nxt  = 1'b0;
            end
          end else begin
            phase_nxt = phase_inc;
            coil_nxt  = (phase_inc < dw_e);
          end
          // Only falls produced by the dwell comparison count as sparks.
          fall_nxt = ign_coil && !coil_nxt;
        end
      end

      default: begin
        state_nxt = IDLE;
        coil_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/ign_coil_sim.md
# ign_coil_sim

Synthetic ignition-coil waveform generator: the transmitting end of the `ign_coil` input that `efi_timer` consumes. It produces a programmable-period, programmable-dwell coil signal from the shared 1 MHz `pulse1m` tick. It supports continuous or fixed-count bursts, so the EFI path can be exercised on the DE0-Nano bench without an engine. It sits beside `efi_timer`, fed by the same realtime counter chain, and its `ign_coil` output is muxed onto the `efi_timer.ign_coil` input in test builds.

## Interface
- `CW`, default 16: width of the period, dwell and count fields.
- `sysclk` input 1: system clock, 50 MHz.
- `sysreset` input 1: reset, asynchronous, active-high.
- `pulse1m` input 1: one-`sysclk` strobe at 1 MHz; all waveform timing counts these.
- `run` input 1: level enable for waveform generation.
- `period_us` input CW: full coil cycle length in µs, from rising edge to rising edge.
- `dwell_us` input CW: coil-high time per cycle, in µs.
- `burst_len` input CW: number of cycles to emit; 0 = continuous.
- `ign_coil` output 1: registered coil waveform.
- `spark_event` output 1: one-`sysclk` pulse on each coil falling edge, i.e. the spark.
- `busy` output 1: high while in state RUN.
- `burst_done` output 1: one-`sysclk` pulse when a finite burst completes.
- `cycle_count` output CW: cycles completed since the last start; wraps modulo 2^CW.

## Operation
- State IDLE:
  - `ign_coil`=0 and `phase`=0.
  - On a `pulse1m` with `run`=1 and latched-to-be `period_us`≠0:
    - latch `period_us`, `dwell_us` and `burst_len` into `per_l`, `dw_l`, `bl_l`;
    - clear `cycle_count`;
    - enter RUN with `phase`=0.
  - `run`=1 with `period_us`=0 stays in IDLE.
- Dwell clamp: effective dwell `dw_e` = min(`dw_l`, `per_l`−1), so every cycle contains at least one µs low. `dw_l`=0 gives a constant-low coil with no `spark_event`.
- State RUN, on each `pulse1m`:
  - If `phase` == `per_l`−1, end of cycle:
    - `phase`←0 and `cycle_count`++;
    - re-latch `per_l`, `dw_l` from the inputs; new values take effect only at cycle boundaries;
    - if `bl_l`≠0 and the incremented count equals `bl_l`: go to IDLE and pulse `burst_done`;
    - if the re-latched `period_us`=0: go to IDLE without `burst_done`.
  - Otherwise `phase`++.
- Coil level: `ign_coil` is registered as (next `phase` < `dw_e`) while in RUN, and 0 otherwise.
- Spark: `spark_event` is 1 in the `sysclk` cycle after `ign_coil` goes 1→0 inside RUN. The forced-low on abort and the clear on reset produce no `spark_event`.
- Abort: `run`=0 in RUN takes effect on the next `sysclk`, not the next `pulse1m`:
  - go to IDLE, `ign_coil`←0;
  - no `spark_event`, no `burst_done`;
  - `cycle_count` holds its value.
- `burst_len` changes during RUN are ignored until the next start.

## Timing
- Reset: async assert forces IDLE, with these values:
  - `ign_coil`=0, `spark_event`=0, `busy`=0, `burst_done`=0, `cycle_count`=0;
  - `phase`=0 and all latches 0.
- Deassert is used synchronously; `sysreset` is pre-synchronized upstream.
- Start latency: `ign_coil` and `busy` rise on the `sysclk` edge that samples the starting `pulse1m`.
- Coil edge timing: every `ign_coil` edge is aligned to a `pulse1m`-sampling edge.
  - High time = `dw_e` µs exactly (±0 `sysclk`).
  - Period = `per_l` µs.
- `spark_event` lags the coil falling edge by 1 `sysclk`.
- `burst_done` coincides with `busy` falling.
- `cycle_count` updates on the same edge as the cycle-end `phase` wrap.
- Simultaneous events:
  - `run` falling on a cycle-end `pulse1m`: abort wins and `cycle_count` still increments.
  - `sysreset` overrides everything.
- Wrap-around: `cycle_count` wraps 0xFFFF→0 at CW=16 in continuous mode, with no side effect.

## Test plan
- Nominal drive:
  - stimulus: `period_us`=10000, `dwell_us`=5000, `burst_len`=0, `run`=1;
  - response: coil high 5.000 ms / low 5.000 ms, `spark_event` every 10 ms, `cycle_count` 1,2,3… at each 10 ms wrap.
- Burst:
  - stimulus: `burst_len`=4, `period_us`=14000, `dwell_us`=7000;
  - response: exactly 4 coil pulses and 4 `spark_event`s; `burst_done` at 56 ms; `busy`=0 after; `cycle_count`=4 held.
- Clamp and zero:
  - `dwell_us`=20, `period_us`=10 → high 9 µs, low 1 µs;
  - `dwell_us`=0 → coil stays 0, `busy`=1, no sparks;
  - `period_us`=0 with `run`=1 → remains IDLE.
- Mid-run parameter change:
  - stimulus: change `period_us` 10000→6000 during a cycle;
  - response: the current cycle completes at 10 ms and the next cycle measures 6 ms.
- Abort:
  - stimulus: `run`→0 2 ms into dwell;
  - response: coil low within 1 `sysclk`, no `spark_event`, no `burst_done`, `cycle_count` unchanged.
- Reset mid-run:
  - stimulus: `sysreset` asserted 3 ms into a cycle;
  - response: all outputs 0 immediately (asynchronous); after release with `run`=1, restart at the next `pulse1m` with `cycle_count`=0.
- Loopback:
  - stimulus: feed `ign_coil` into `efi_timer`;
  - response: one `puff_event` per `spark_event`.
